// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: opcode and REGIMM rt encodings plus field-extract helpers.
package mips_isa_pkg;

    localparam int OPCODE_W = 6;
    localparam int RT_W     = 5;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [RT_W-1:0]     rt_t;

    localparam opcode_t OP_REGIMM = 6'b000001;
    localparam opcode_t OP_BEQ    = 6'b000100;
    localparam opcode_t OP_BNE    = 6'b000101;
    localparam opcode_t OP_BLEZ   = 6'b000110;
    localparam opcode_t OP_BGTZ   = 6'b000111;
    localparam opcode_t OP_BEQL   = 6'b010100;
    localparam opcode_t OP_BNEL   = 6'b010101;
    localparam opcode_t OP_BLEZL  = 6'b010110;
    localparam opcode_t OP_BGTZL  = 6'b010111;

    localparam rt_t RT_BLTZ   = 5'b00000;
    localparam rt_t RT_BGEZ   = 5'b00001;
    localparam rt_t RT_BLTZAL = 5'b10000;
    localparam rt_t RT_BGEZAL = 5'b10001;

    // Primary opcode lives in the top six bits of every instruction format.
    function automatic opcode_t getOpcode(input logic [31:0] instrWord);
        return instrWord[31:26];
    endfunction

    // For REGIMM the rt slot selects the branch flavour rather than a register.
    function automatic rt_t getRt(input logic [31:0] instrWord);
        return instrWord[20:16];
    endfunction

endpackage

// File: rtl/branch_cond_logic.sv
// Pure combinational branch decode and condition evaluation.
module branch_cond_logic
    import mips_isa_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               jump,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic [INSTR_W-1:0] instr,
    output logic               is_branch,
    output logic               taken
);

    opcode_t opcode;
    rt_t     rtField;
    logic    aNeg;
    logic    aZero;
    logic    abEqual;
    logic    cond;

    assign opcode  = getOpcode(instr[31:0]);
    assign rtField = getRt(instr[31:0]);
    assign aNeg    = op_a[DATA_W-1];
    assign aZero   = (op_a == '0);
    assign abEqual = (op_a == op_b);

    // Decode the branch kind and pick its condition; a jump overrides everything.
    always_comb begin
        is_branch = 1'b0;
        cond      = 1'b0;
        unique case (opcode)
            OP_BEQ, OP_BEQL: begin
                is_branch = 1'b1;
                cond      = abEqual;
            end
            OP_BNE, OP_BNEL: begin
                is_branch = 1'b1;
                cond      = !abEqual;
            end
            OP_BLEZ, OP_BLEZL: begin
                is_branch = 1'b1;
                cond      = aNeg | aZero;
            end
            OP_BGTZ, OP_BGTZL: begin
                is_branch = 1'b1;
                cond      = !aNeg & !aZero;
            end
            OP_REGIMM: begin
                if (rtField == RT_BLTZ || rtField == RT_BLTZAL) begin
                    is_branch = 1'b1;
                    cond      = aNeg;
                end else if (rtField == RT_BGEZ || rtField == RT_BGEZAL) begin
                    is_branch = 1'b1;
                    cond      = !aNeg;
                end
            end
            default: begin
                is_branch = 1'b0;
                cond      = 1'b0;
            end
        endcase
        if (jump) begin
            is_branch = 1'b0;
        end
        taken = is_branch & cond;
    end

endmodule

// File: rtl/branch_compare.sv
// Branch-condition evaluator: combinational decision plus freezable registered copies.
module branch_compare
    import mips_isa_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int INSTR_W = 32
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               freeze,
    input  logic               jump,
    input  logic [DATA_W-1:0]  op_a,
    input  logic [DATA_W-1:0]  op_b,
    input  logic [INSTR_W-1:0] instr,
    output logic               is_branch,
    output logic               taken,
    output logic               taken_q,
    output logic               is_branch_q
);

    logic taken_d;
    logic is_branch_d;

    branch_cond_logic #(
        .DATA_W (DATA_W),
        .INSTR_W(INSTR_W)
    ) u_cond (
        .jump     (jump),
        .op_a     (op_a),
        .op_b     (op_b),
        .instr    (instr),
        .is_branch(is_branch),
        .taken    (taken)
    );

    // Freeze holds the pipeline copy; otherwise capture the live decision.
    always_comb begin
        taken_d     = taken_q;
        is_branch_d = is_branch_q;
        if (!freeze) begin
            taken_d     = taken;
            is_branch_d = is_branch;
        end
    end

    // Pipeline registers, cleared asynchronously while RESET is low.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            taken_q     <= 1'b0;
            is_branch_q <= 1'b0;
        end else begin
            taken_q     <= taken_d;
            is_branch_q <= is_branch_d;
        end
    end

endmodule

// File: tb/tb_branch_compare.sv
// Directed testbench for branch_compare with hand-computed expectations.
module tb_branch_compare;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        freeze = 1'b0;
    logic        jump = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [31:0] instr = '0;
    logic        is_branch;
    logic        taken;
    logic        taken_q;
    logic        is_branch_q;

    int assertCount = 0;
    int failCount   = 0;

    branch_compare dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .freeze     (freeze),
        .jump       (jump),
        .op_a       (op_a),
        .op_b       (op_b),
        .instr      (instr),
        .is_branch  (is_branch),
        .taken      (taken),
        .taken_q    (taken_q),
        .is_branch_q(is_branch_q)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    always #5 CLK = ~CLK;

    // Change inputs on the falling edge, then let combinational paths settle.
    task automatic applyStimulus(input logic j, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] ins);
        @(negedge CLK);
        jump  = j;
        op_a  = a;
        op_b  = b;
        instr = ins;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Wait until just after the next rising edge to sample the registers.
    task automatic afterEdge();
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] sweepA   [5] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                                  32'h7FFF_FFFF, 32'h8000_0000};
    logic        expBgtz  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        expBlez  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        expBne   [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        expBltz  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        $display("[TB] starting branch_compare test");

        // Reset state
        #1;
        checkOutput("reset_taken_q", taken_q, 1'b0);
        checkOutput("reset_is_branch_q", is_branch_q, 1'b0);
        checkOutput("nop_taken", taken, 1'b0);
        checkOutput("nop_is_branch", is_branch, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;

        // BEQ equal, then registered copy
        applyStimulus(1'b0, 32'h1234_5678, 32'h1234_5678, 32'h1022_0003);
        checkOutput("beq_eq_taken", taken, 1'b1);
        checkOutput("beq_eq_is_branch", is_branch, 1'b1);
        afterEdge();
        checkOutput("beq_taken_q", taken_q, 1'b1);
        checkOutput("beq_is_branch_q", is_branch_q, 1'b1);

        // BEQ differing in LSB
        applyStimulus(1'b0, 32'h1234_5678, 32'h1234_5679, 32'h1022_0003);
        checkOutput("beq_ne_taken", taken, 1'b0);
        checkOutput("beq_ne_is_branch", is_branch, 1'b1);
        afterEdge();
        checkOutput("beq_ne_taken_q", taken_q, 1'b0);

        // BEQL differing only in the MSB
        applyStimulus(1'b0, 32'h8000_0000, 32'h0000_0000, 32'h5022_0003);
        checkOutput("beql_msb_taken", taken, 1'b0);

        // Signed sweep across BNE, BLEZ, BGTZ, BGTZL, BLTZ
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, sweepA[i], 32'h0, 32'h1422_0003);
            checkOutput($sformatf("bne_%0d", i), taken, expBne[i]);
            applyStimulus(1'b0, sweepA[i], 32'h0, 32'h1820_0003);
            checkOutput($sformatf("blez_%0d", i), taken, expBlez[i]);
            applyStimulus(1'b0, sweepA[i], 32'h0, 32'h1C20_0003);
            checkOutput($sformatf("bgtz_%0d", i), taken, expBgtz[i]);
            applyStimulus(1'b0, sweepA[i], 32'h0, 32'h5C20_0003);
            checkOutput($sformatf("bgtzl_%0d", i), taken, expBgtz[i]);
            applyStimulus(1'b0, sweepA[i], 32'h0, 32'h0420_0003);
            checkOutput($sformatf("bltz_%0d", i), taken, expBltz[i]);
        end

        // REGIMM variants
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0420_0003);
        checkOutput("bltz_neg", taken, 1'b1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0430_0003);
        checkOutput("bltzal_neg", taken, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0421_0003);
        checkOutput("bgez_zero", taken, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0431_0003);
        checkOutput("bgezal_zero", taken, 1'b1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0421_0003);
        checkOutput("bgez_neg", taken, 1'b0);
        checkOutput("bgez_neg_is_branch", is_branch, 1'b1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0422_0003);
        checkOutput("regimm_rt2_is_branch", is_branch, 1'b0);
        checkOutput("regimm_rt2_taken", taken, 1'b0);

        // Jump suppression and a non-branch opcode
        applyStimulus(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h1022_0003);
        checkOutput("jump_taken", taken, 1'b0);
        checkOutput("jump_is_branch", is_branch, 1'b0);
        applyStimulus(1'b0, 32'h5, 32'h5, 32'h0022_1820);
        checkOutput("add_is_branch", is_branch, 1'b0);
        checkOutput("add_taken", taken, 1'b0);

        // Asynchronous reset mid-cycle
        applyStimulus(1'b0, 32'h1234_5678, 32'h1234_5678, 32'h1022_0003);
        afterEdge();
        checkOutput("pre_reset_taken_q", taken_q, 1'b1);
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        checkOutput("async_reset_taken_q", taken_q, 1'b0);
        checkOutput("async_reset_is_branch_q", is_branch_q, 1'b0);

        // Release reset while frozen: registers stay clear
        freeze = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 3; i++) begin
            afterEdge();
            checkOutput($sformatf("frozen_taken_q_%0d", i), taken_q, 1'b0);
            checkOutput($sformatf("frozen_is_branch_q_%0d", i), is_branch_q, 1'b0);
        end
        @(negedge CLK);
        freeze = 1'b0;
        afterEdge();
        checkOutput("unfrozen_taken_q", taken_q, 1'b1);
        checkOutput("unfrozen_is_branch_q", is_branch_q, 1'b1);

        // Freeze holds a set value against a not-taken input
        freeze = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 32'h0000_0000);
        afterEdge();
        checkOutput("hold_taken_q", taken_q, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
